uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART byte receiver and the waveform datapath. It assembles 5-byte command frames from received bytes, validates header and checksum, and applies the command to the generator configuration registers (waveform select, frequency word, amplitude, run enable). It is the only writer of generator configuration; downstream blocks consume the register outputs and the cfg_update strobe.

Parameters:
TIMEOUT_CYC, 2560, inter-byte timeout in clk_16u cycles (about 16 byte times at 16x oversampling)
HEADER, 8'hAA, frame start byte
FREQ_W, 16, frequency word width; fixed at 16 for this frame format

Ports:
clk_16u  in  1  16x-baud system clock; the only clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte from the UART receiver
rx_ready  in  1  receiver byte-valid level; a new byte is signalled by its 0->1 transition
rx_error  in  1  receiver framing/stop-bit error level
wave_sel  out  2  0=sine, 1=square, 2=triangle, 3=sawtooth
freq_word  out  16  phase-increment word
amp  out  8  amplitude scale
run_en  out  1  generator enable
cfg_update  out  1  one-cycle pulse when any config register is written
frame_err  out  1  one-cycle pulse on a rejected or aborted frame
busy  out  1  high while a frame is in progress (state != S_IDLE)

Behaviour:
- Reset values (rst=1 at a clk_16u edge): wave_sel=0, freq_word=16'h0100, amp=8'hFF, run_en=0, cfg_update=0, frame_err=0, state=S_IDLE, timer=0, rx_ready_d=0. Reset mid-frame discards the partial frame.
- Byte event: byte_evt = rx_ready & ~rx_ready_d, where rx_ready_d is registered every cycle. A rising edge with rx_error=1 is an error event, not a byte.
- Frame: HDR, CMD, D1 (MSB), D0 (LSB), CHK, with CHK = CMD ^ D1 ^ D0.
- States: S_IDLE -> S_CMD -> S_D1 -> S_D0 -> S_CHK -> S_APPLY -> S_IDLE.
- S_IDLE: a byte_evt with rx_data==HEADER moves to S_CMD. Any other byte is ignored silently, with no frame_err.
- S_CMD/S_D1/S_D0: latch the byte on byte_evt and advance. A header byte here is data, not a resync.
- S_CHK: on byte_evt, a match moves to S_APPLY. A mismatch pulses frame_err and returns to S_IDLE.
- S_APPLY is exactly one cycle. Config registers and the cfg_update pulse change on the edge leaving S_APPLY, so new values appear 2 cycles after the CHK byte_evt cycle.
- Commands:
  - 0x01: wave_sel=D0[1:0]
  - 0x02: freq_word={D1,D0}
  - 0x03: amp=D0
  - 0x04: run_en=D0[0]
  - 0x05: all registers to reset values
  - Any other CMD: no register change, no cfg_update, frame_err pulse instead.
- cfg_update also pulses when the written value equals the old value.
- Timeout: in any state other than S_IDLE/S_APPLY, the timer counts cycles since the last byte_evt and clears on each byte_evt. When timer reaches TIMEOUT_CYC-1, the block pulses frame_err and returns to S_IDLE.
- Receiver error: an error event in any non-idle state pulses frame_err and returns to S_IDLE. In S_IDLE an error event is ignored.
- Simultaneous events: rst dominates everything; a byte_evt in the same cycle as timer expiry wins and the byte is accepted.
- Pulse width: frame_err and cfg_update are never high together and never high for more than 1 cycle.

Decomposition:
- Shared package: state encoding, HEADER, command opcodes CMD_WAVE/CMD_FREQ/CMD_AMP/CMD_RUN/CMD_DEFAULT, reset defaults (16'h0100, 8'hFF), and the wave_sel encodings.
- One natural sub-module: cmd_timeout_timer (load/clear on byte, enable, expire pulse).
- Edge detect, FSM and config registers stay in uart_cmd_ctrl.

Test Plan:
1. After reset, send AA 02 12 34 24 -> freq_word=16'h1234, one cfg_update pulse 2 cycles after CHK edge, frame_err never high.
2. Send AA 01 00 03 02 then AA 04 00 01 05 -> wave_sel=3, then run_en=1; exactly two cfg_update pulses.
3. Send AA 03 00 80 00 (bad CHK, correct is 83) -> amp stays 8'hFF, one frame_err pulse, busy drops; then AA 03 00 80 83 -> amp=8'h80.
4. Send AA 02, then idle TIMEOUT_CYC cycles -> frame_err pulse at expiry, state S_IDLE; then AA 02 00 10 12 -> freq_word=16'h0010.
5. Send AA 02 12, assert rst 1 cycle, then 34 24 -> all outputs at reset values, no cfg_update, no frame_err (bytes ignored in S_IDLE).
6. Send AA 02 with an rx_error edge on the third byte, then AA 07 00 00 07 -> two frame_err pulses (abort, unknown CMD), no config change.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants for the UART command sequencer: FSM encoding, frame
// header, command opcodes, register reset defaults and waveform encodings.
package uart_cmd_ctrl_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_D1    = 3'd2;
  localparam logic [2:0] S_D0    = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_APPLY = 3'd5;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;

  // Command opcodes
  localparam logic [7:0] CMD_WAVE    = 8'h01;
  localparam logic [7:0] CMD_FREQ    = 8'h02;
  localparam logic [7:0] CMD_AMP     = 8'h03;
  localparam logic [7:0] CMD_RUN     = 8'h04;
  localparam logic [7:0] CMD_DEFAULT = 8'h05;

  // Generator configuration reset values
  localparam logic [15:0] FREQ_RST = 16'h0100;
  localparam logic [7:0]  AMP_RST  = 8'hFF;

  // Waveform select encodings
  localparam logic [1:0] WAVE_SINE     = 2'd0;
  localparam logic [1:0] WAVE_SQUARE   = 2'd1;
  localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
  localparam logic [1:0] WAVE_SAWTOOTH = 2'd3;

  // Checksum over the three payload bytes of a frame
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] d1,
                                           input logic [7:0] d0);
    return cmd ^ d1 ^ d0;
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout counter: cleared by every accepted byte, counts while
// enabled, and flags expiry when it reaches TIMEOUT_CYC-1.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 2560
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] timer;

  assign expire = enable && (timer == TW'(TIMEOUT_CYC - 1));

  // Count cycles since the last byte; hold at the limit so it never wraps
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      timer <= '0;
    end else if (!expire) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: assembles HDR/CMD/D1/D0/CHK frames from received
// bytes, validates them and writes the waveform generator configuration.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2560,
  parameter logic [7:0]  HEADER      = HEADER_BYTE,
  parameter int unsigned FREQ_W      = 16
) (
  input  logic              clk_16u,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  output logic [1:0]        wave_sel,
  output logic [FREQ_W-1:0] freq_word,
  output logic [7:0]        amp,
  output logic              run_en,
  output logic              cfg_update,
  output logic              frame_err,
  output logic              busy
);

  logic       rx_ready_d;
  logic [2:0] state;
  logic [7:0] cmd, d1, d0;
  logic       rise, byte_evt, err_evt;
  logic       timer_en, expire;

  assign rise     = rx_ready & ~rx_ready_d;
  assign byte_evt = rise & ~rx_error;
  assign err_evt  = rise & rx_error;
  assign busy     = (state != S_IDLE);
  assign timer_en = (state != S_IDLE) && (state != S_APPLY);

  cmd_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk_16u),
    .rst   (rst),
    .clear (byte_evt),
    .enable(timer_en),
    .expire(expire)
  );

  // Frame FSM, payload capture and generator configuration registers
  always_ff @(posedge clk_16u) begin
    if (rst) begin
      rx_ready_d <= 1'b0;
      state      <= S_IDLE;
      cmd        <= '0;
      d1         <= '0;
      d0         <= '0;
      wave_sel   <= WAVE_SINE;
      freq_word  <= FREQ_RST;
      amp        <= AMP_RST;
      run_en     <= 1'b0;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_ready_d <= rx_ready;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // Non-header bytes and receiver errors are dropped silently here
          if (byte_evt && rx_data == HEADER) state <= S_CMD;
        end
        S_CMD, S_D1, S_D0, S_CHK: begin
          // A byte in the expiry cycle wins over the timeout
          if (err_evt) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (byte_evt) begin
            case (state)
              S_CMD: begin cmd <= rx_data; state <= S_D1; end
              S_D1:  begin d1  <= rx_data; state <= S_D0; end
              S_D0:  begin d0  <= rx_data; state <= S_CHK; end
              default: begin
                if (rx_data == frame_chk(cmd, d1, d0)) begin
                  state <= S_APPLY;
                end else begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
                end
              end
            endcase
          end else if (expire) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_APPLY: begin
          state <= S_IDLE;
          // A receiver error landing in the apply cycle aborts the write
          if (err_evt) begin
            frame_err <= 1'b1;
          end else begin
            case (cmd)
              CMD_WAVE: begin wave_sel  <= d0[1:0];  cfg_update <= 1'b1; end
              CMD_FREQ: begin freq_word <= {d1, d0}; cfg_update <= 1'b1; end
              CMD_AMP:  begin amp       <= d0;       cfg_update <= 1'b1; end
              CMD_RUN:  begin run_en    <= d0[0];    cfg_update <= 1'b1; end
              CMD_DEFAULT: begin
                wave_sel   <= WAVE_SINE;
                freq_word  <= FREQ_RST;
                amp        <= AMP_RST;
                run_en     <= 1'b0;
                cfg_update <= 1'b1;
              end
              default: frame_err <= 1'b1;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
